// File: rtl/vga_ctrl_param.sv
// Parametrised VGA/DVI raster timing generator with request lead, frame-boundary enable,
// linear read address and RGB565 to RGB888 expansion, all in the vga_clk domain.
module vga_ctrl_param #(
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACT    = 640,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACT    = 480,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int REQ_LEAD = 1,
   parameter int CNT_W    = 12,
   parameter int ADDR_W   = 19
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic              en,
   input  logic [15:0]       pix_data,
   output logic              pix_data_req,
   output logic [ADDR_W-1:0] address,
   output logic [CNT_W-1:0]  pix_x,
   output logic [CNT_W-1:0]  pix_y,
   output logic              rgb_valid,
   output logic [7:0]        vga_red,
   output logic [7:0]        vga_green,
   output logic [7:0]        vga_blue,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_start,
   output logic              line_start,
   output logic              vga_blank,
   output logic              vga_sync,
   output logic              vga_clock
);

   localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
   localparam int H_TOTAL = H_BLANK + H_ACT;
   localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
   localparam int V_TOTAL = V_BLANK + V_ACT;

   localparam logic [CNT_W-1:0] C_H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_H_BLANK   = CNT_W'(H_BLANK);
   localparam logic [CNT_W-1:0] C_V_BLANK   = CNT_W'(V_BLANK);
   localparam logic [CNT_W-1:0] C_HS_BEG    = CNT_W'(H_FRONT);
   localparam logic [CNT_W-1:0] C_HS_END    = CNT_W'(H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] C_VS_BEG    = CNT_W'(V_FRONT);
   localparam logic [CNT_W-1:0] C_VS_END    = CNT_W'(V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] C_REQ_BEG   = CNT_W'(H_BLANK - REQ_LEAD);
   localparam logic [CNT_W-1:0] C_REQ_END   = CNT_W'(H_TOTAL - REQ_LEAD);
   localparam logic             C_HS_ON     = 1'(HS_POL);
   localparam logic             C_VS_ON     = 1'(VS_POL);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_h, r_v, w_h_nxt, w_v_nxt;
   logic              w_run_nxt, w_v_act, w_active, w_req, w_hs_on, w_vs_on;
   logic              w_line_start, w_frame_start;
   logic              r_req, r_valid, r_hsync, r_vsync, r_frame_start, r_line_start;
   logic [CNT_W-1:0]  r_pix_x, r_pix_y;
   logic [ADDR_W-1:0] r_addr;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = '0;
      w_v_nxt     = '0;
      case (r_state)
         S_IDLE: if (en) w_state_nxt = S_RUN;
         S_RUN: begin
            if (r_h != C_H_LAST) begin
               w_h_nxt = r_h + CNT_W'(1);
               w_v_nxt = r_v;
            end else if (r_v != C_V_LAST) begin
               w_v_nxt = r_v + CNT_W'(1);
            end else if (!en) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next-state counters so the registered values line up with (h, v).
   assign w_run_nxt     = (w_state_nxt == S_RUN);
   assign w_v_act       = (w_v_nxt >= C_V_BLANK);
   assign w_active      = w_run_nxt && w_v_act && (w_h_nxt >= C_H_BLANK);
   assign w_req         = w_run_nxt && w_v_act && (w_h_nxt >= C_REQ_BEG) && (w_h_nxt < C_REQ_END);
   assign w_hs_on       = w_run_nxt && (w_h_nxt >= C_HS_BEG) && (w_h_nxt < C_HS_END);
   assign w_vs_on       = w_run_nxt && (w_v_nxt >= C_VS_BEG) && (w_v_nxt < C_VS_END);
   assign w_line_start  = w_run_nxt && (w_h_nxt == '0);
   assign w_frame_start = w_line_start && (w_v_nxt == '0);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         r_state       <= S_IDLE;
         r_h           <= '0;
         r_v           <= '0;
         r_req         <= 1'b0;
         r_valid       <= 1'b0;
         r_hsync       <= ~C_HS_ON;
         r_vsync       <= ~C_VS_ON;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_addr        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_h           <= w_h_nxt;
         r_v           <= w_v_nxt;
         r_req         <= w_req;
         r_valid       <= w_active;
         r_hsync       <= w_hs_on ? C_HS_ON : ~C_HS_ON;
         r_vsync       <= w_vs_on ? C_VS_ON : ~C_VS_ON;
         r_frame_start <= w_frame_start;
         r_line_start  <= w_line_start;
         r_pix_x       <= w_active ? (w_h_nxt - C_H_BLANK) : '0;
         r_pix_y       <= w_active ? (w_v_nxt - C_V_BLANK) : '0;
         // Address k is shown with request k; it steps after each request clock.
         if (!w_run_nxt || w_frame_start)
            r_addr <= '0;
         else if (r_req)
            r_addr <= r_addr + ADDR_W'(1);
      end
   end

   assign pix_data_req = r_req;
   assign address      = r_addr;
   assign pix_x        = r_pix_x;
   assign pix_y        = r_pix_y;
   assign rgb_valid    = r_valid;
   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign frame_start  = r_frame_start;
   assign line_start   = r_line_start;
   assign vga_blank    = r_valid;
   assign vga_sync     = 1'b1;
   assign vga_clock    = ~vga_clk;

   assign vga_red   = r_valid ? {pix_data[15:11], pix_data[15:13]} : 8'd0;
   assign vga_green = r_valid ? {pix_data[10:5],  pix_data[10:9]}  : 8'd0;
   assign vga_blue  = r_valid ? {pix_data[4:0],   pix_data[4:2]}   : 8'd0;

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param on a small 17x8 raster: frame-index model checked every cycle,
// plus hand-computed timing, colour, enable and reset vectors.
module tb_vga_ctrl_param;

   localparam int HF = 3, HS = 4, HBK = 2, HA = 8;
   localparam int VF = 2, VS = 1, VBK = 1, VA = 4;
   localparam int HSP = 1, VSP = 0, L = 3, CW = 12, AW = 19;
   localparam int HB = HF + HS + HBK, HT = HB + HA;
   localparam int VB = VF + VS + VBK, VT = VB + VA;
   localparam int FRAME = HT * VT;

   logic          vga_clk = 1'b0;
   logic          sys_rst_n, en;
   logic [15:0]   pix_data = '0;
   logic          pix_data_req, rgb_valid, hsync, vsync, frame_start, line_start;
   logic          vga_blank, vga_sync, vga_clock;
   logic [AW-1:0] address;
   logic [CW-1:0] pix_x, pix_y;
   logic [7:0]    vga_red, vga_green, vga_blue;

   int n_vec = 0, n_mis = 0;

   vga_ctrl_param #(
      .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK), .H_ACT(HA),
      .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK), .V_ACT(VA),
      .HS_POL(HSP), .VS_POL(VSP), .REQ_LEAD(L), .CNT_W(CW), .ADDR_W(AW)
   ) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en), .pix_data(pix_data),
      .pix_data_req(pix_data_req), .address(address), .pix_x(pix_x), .pix_y(pix_y),
      .rgb_valid(rgb_valid), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
      .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .line_start(line_start),
      .vga_blank(vga_blank), .vga_sync(vga_sync), .vga_clock(vga_clock)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] widen(input int val, input int bits);
      return (bits == 5) ? 8'((val << 3) | (val >> 2)) : 8'((val << 2) | (val >> 4));
   endfunction

   // Model: running flag plus the clock index within the frame.
   bit m_ok = 0, m_run = 0;
   int m_n = 0;
   always @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         m_run = 0; m_n = 0; m_ok = 1;
      end else if (!m_run) begin
         if (en) begin m_run = 1; m_n = 0; end
      end else if (m_n == FRAME - 1) begin
         m_n = 0; m_run = en;
      end else begin
         m_n++;
      end
   end

   // Memory: returns the address requested L clocks earlier, or a forced constant.
   logic [AW-1:0] hist [8] = '{default: '0};
   int            wp = 0;
   bit            force_on = 0, mem_forced = 0;
   logic [15:0]   force_val = '0, mem_val = '0;
   always @(negedge vga_clk) begin
      hist[wp] = address;
      wp = (wp + 1) % 8;
   end
   always @(posedge vga_clk) begin
      #1;
      mem_forced = force_on;
      mem_val    = force_val;
      pix_data   = force_on ? force_val : 16'(hist[(wp + 8 - L) % 8]);
   end

   // Compare every cycle against the model.
   always @(negedge vga_clk) begin : cmp
      int h, v, ex, ey, reqs, p;
      bit act, req;
      if (m_ok) begin
         h    = m_n % HT;
         v    = m_n / HT;
         act  = m_run && h >= HB && v >= VB;
         req  = m_run && v >= VB && h >= HB - L && h < HT - L;
         ex   = act ? h - HB : 0;
         ey   = act ? v - VB : 0;
         reqs = 0;
         if (m_run && v >= VB) begin
            reqs = (v - VB) * HA + ((h - (HB - L) < 0) ? 0 : (h - (HB - L) > HA) ? HA : h - (HB - L));
         end
         p = mem_forced ? int'(mem_val) : ((ey * HA + ex) & 16'hFFFF);
         check("rgb_valid", 32'(rgb_valid), 32'(act));
         check("vga_blank", 32'(vga_blank), 32'(act));
         check("req", 32'(pix_data_req), 32'(req));
         check("address", 32'(address), 32'(reqs));
         check("pix_x", 32'(pix_x), 32'(ex));
         check("pix_y", 32'(pix_y), 32'(ey));
         check("hsync", 32'(hsync), 32'((m_run && h >= HF && h < HF + HS) ? HSP : 1 - HSP));
         check("vsync", 32'(vsync), 32'((m_run && v >= VF && v < VF + VS) ? VSP : 1 - VSP));
         check("frame_start", 32'(frame_start), 32'(m_run && m_n == 0));
         check("line_start", 32'(line_start), 32'(m_run && h == 0));
         check("vga_sync", 32'(vga_sync), 32'd1);
         check("vga_clock", 32'(vga_clock), 32'd1);
         if (act && !mem_forced) check("pix_data", 32'(pix_data), 32'(p));
         check("red", 32'(vga_red), act ? 32'(widen(p >> 11, 5)) : 32'd0);
         check("green", 32'(vga_green), act ? 32'(widen((p >> 5) & 63, 6)) : 32'd0);
         check("blue", 32'(vga_blue), act ? 32'(widen(p & 31, 5)) : 32'd0);
      end
   end

   // Called at a negedge showing frame_start; walks one full frame.
   task automatic measure_frame();
      int idx = 0, reqs = 0, hs_n = 0, vs_n = 0, lines = 0, line2 = -1;
      int hs_first = -1, vs_first = -1, req_first = -1, addr_last = -1;
      do begin
         if (pix_data_req) begin
            if (req_first < 0) req_first = idx;
            reqs++;
            addr_last = int'(address);
         end
         if (hsync == 1'(HSP)) begin hs_n++; if (hs_first < 0) hs_first = idx; end
         if (vsync == 1'(VSP)) begin vs_n++; if (vs_first < 0) vs_first = idx; end
         if (line_start) begin lines++; if (lines == 2) line2 = idx; end
         @(negedge vga_clk);
         idx++;
      end while (!frame_start && idx < 1000);
      check("frame_period", 32'(idx), 32'd136);
      check("line_period", 32'(line2), 32'd17);
      check("lines_per_frame", 32'(lines), 32'd8);
      check("reqs_per_frame", 32'(reqs), 32'd32);
      check("first_req_idx", 32'(req_first), 32'd74);
      check("last_req_addr", 32'(addr_last), 32'd31);
      check("hsync_clocks", 32'(hs_n), 32'd32);
      check("hsync_first", 32'(hs_first), 32'd3);
      check("vsync_clocks", 32'(vs_n), 32'd17);
      check("vsync_first", 32'(vs_first), 32'd34);
   endtask

   task automatic colour_case(input logic [15:0] val, input logic [7:0] r, g, b);
      int k = 0;
      force_val = val;
      force_on  = 1;
      @(posedge vga_clk);
      @(negedge vga_clk);
      while (!rgb_valid && k < 300) begin @(negedge vga_clk); k++; end
      check("colour_wait", 32'(rgb_valid), 32'd1);
      check("colour_red", 32'(vga_red), 32'(r));
      check("colour_green", 32'(vga_green), 32'(g));
      check("colour_blue", 32'(vga_blue), 32'(b));
      force_on = 0;
   endtask

   task automatic wait_model(input int target);
      int k = 0;
      while (!(m_run && m_n == target) && k < 1000) begin
         @(posedge vga_clk); #2; k++;
      end
      check("wait_model", 32'(m_n), 32'(target));
   endtask

   initial begin : main
      int ls, fs, val, rq;
      sys_rst_n = 1'b0;
      en        = 1'b0;
      repeat (3) @(posedge vga_clk);
      #2 sys_rst_n = 1'b1;
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      check("idle_hsync", 32'(hsync), 32'd0);
      check("idle_vsync", 32'(vsync), 32'd1);
      check("idle_req", 32'(pix_data_req), 32'd0);
      check("idle_frame_start", 32'(frame_start), 32'd0);

      en = 1'b1;
      @(posedge vga_clk);
      @(negedge vga_clk);
      check("first_frame_start", 32'(frame_start), 32'd1);
      measure_frame();

      colour_case(16'hF800, 8'hFF, 8'h00, 8'h00);
      colour_case(16'h07E0, 8'h00, 8'hFF, 8'h00);
      colour_case(16'h001F, 8'h00, 8'h00, 8'hFF);
      colour_case(16'h8410, 8'h84, 8'h82, 8'h84);

      // Drop en at line 5, h=1: the frame must still finish, then stay idle.
      wait_model(5 * HT + 1);
      en = 1'b0;
      ls = 0; fs = 0; val = 0; rq = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge vga_clk);
         ls  += int'(line_start);
         fs  += int'(frame_start);
         val += int'(rgb_valid);
         rq  += int'(pix_data_req);
      end
      check("drop_line_starts", 32'(ls), 32'd2);
      check("drop_frame_starts", 32'(fs), 32'd0);
      check("drop_valid_clocks", 32'(val), 32'd24);
      check("drop_req_clocks", 32'(rq), 32'd24);
      check("idle2_hsync", 32'(hsync), 32'd0);
      check("idle2_vsync", 32'(vsync), 32'd1);
      en = 1'b1;
      @(posedge vga_clk);
      @(negedge vga_clk);
      check("reen_frame_start", 32'(frame_start), 32'd1);

      // One-clock reset in the middle of an active line.
      wait_model(6 * HT + 12);
      sys_rst_n = 1'b0;
      @(posedge vga_clk);
      #2 sys_rst_n = 1'b1;
      @(negedge vga_clk);
      check("rst_valid", 32'(rgb_valid), 32'd0);
      check("rst_req", 32'(pix_data_req), 32'd0);
      check("rst_addr", 32'(address), 32'd0);
      check("rst_pix_x", 32'(pix_x), 32'd0);
      check("rst_pix_y", 32'(pix_y), 32'd0);
      check("rst_hsync", 32'(hsync), 32'd0);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_line_start", 32'(line_start), 32'd0);
      @(posedge vga_clk);
      @(negedge vga_clk);
      check("restart_frame_start", 32'(frame_start), 32'd1);
      measure_frame();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule

// File: doc/vga_ctrl_param.md
Name: vga_ctrl_param

Overview:
- Parametrised VGA/DVI raster timing generator, successor to the fixed 640x480 controller. Sits between the frame-buffer read port (SDRAM FIFO) and the VGA DAC / video encoder.
- Both counters run in the single vga_clk domain; nothing is clocked from hsync.
- Adds programmable sync polarity, programmable request lead, a frame-boundary enable, a linear read-address counter, and frame/line strobes. Expands RGB565 to RGB888.

Parameters:
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
H_ACT, 640, active pixels per line
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
V_ACT, 480, active lines
HS_POL, 0, active level of hsync (0 = active-low)
VS_POL, 0, active level of vsync
REQ_LEAD, 1, clocks pix_data_req leads rgb_valid; legal range 1..4
CNT_W, 12, width of pix_x / pix_y
ADDR_W, 19, width of address

Ports:
vga_clk, in, 1, pixel clock
sys_rst_n, in, 1, synchronous active-low reset
en, in, 1, run enable; sampled only at frame boundary
pix_data, in, 16, RGB565; valid REQ_LEAD clocks after pix_data_req
pix_data_req, out, 1, request next pixel
address, out, ADDR_W, linear pixel address of the current request
pix_x, out, CNT_W, active column (0 outside active)
pix_y, out, CNT_W, active row (0 outside active)
rgb_valid, out, 1, active video
vga_red / vga_green / vga_blue, out, 8 each, expanded colour; 0 when rgb_valid=0
hsync, out, 1, horizontal sync
vsync, out, 1, vertical sync
frame_start, out, 1, one-clock pulse at h=0, v=0
line_start, out, 1, one-clock pulse at h=0 of every line
vga_blank, out, 1, equals rgb_valid
vga_sync, out, 1, constant 1
vga_clock, out, 1, ~vga_clk

Behaviour:
- Derived values: H_BLANK = H_FRONT+H_SYNC+H_BACK; H_TOTAL = H_BLANK+H_ACT. V_BLANK and V_TOTAL are derived the same way.
- Counters:
  - h counts 0..H_TOTAL-1 and wraps, so each line is exactly H_TOTAL clocks.
  - v increments on the h wrap and counts 0..V_TOTAL-1.
  - Within each line/frame the order is front porch, sync, back porch, active.
- State machine IDLE/RUN:
  - Reset enters IDLE with h=v=0.
  - IDLE: counters held at 0; all outputs at inactive level. Moves to RUN on the first clock with en=1.
  - RUN: when h=H_TOTAL-1 and v=V_TOTAL-1 (last pixel of the frame), en=0 sends the block to IDLE. Otherwise it stays in RUN and wraps.
  - Deasserting en mid-frame never truncates the frame.
- Output timing: all outputs except the colour buses are registered and decoded from the next-state counters, so they align to the current (h, v) with zero skew.
  - hsync = HS_POL while H_FRONT <= h < H_FRONT+H_SYNC; otherwise ~HS_POL.
  - vsync = VS_POL while V_FRONT <= v < V_FRONT+V_SYNC; otherwise ~VS_POL. vsync changes on the h=0 clock.
  - rgb_valid = RUN && h >= H_BLANK && v >= V_BLANK.
  - pix_x = h-H_BLANK and pix_y = v-V_BLANK while active; otherwise 0.
  - pix_data_req = RUN && v >= V_BLANK && H_BLANK-REQ_LEAD <= h < H_TOTAL-REQ_LEAD. Count per line is exactly H_ACT.
  - frame_start and line_start are asserted only in RUN.
- Address:
  - Incremental counter, no multiplier.
  - Cleared to 0 on frame_start and in IDLE.
  - Incremented after each pix_data_req clock.
  - The address presented with request k of the frame equals k; the final value is H_ACT*V_ACT-1.
- Colour expansion is combinational, gated by rgb_valid:
  - red = {p[15:11], p[15:13]}
  - green = {p[10:5], p[10:9]}
  - blue = {p[4:0], p[4:2]}
- Reset, including mid-line: on the next clock h=v=0, address=0, and the block is in IDLE.
  - Reset values: pix_data_req, rgb_valid, frame_start, line_start = 0; pix_x, pix_y = 0; hsync = ~HS_POL; vsync = ~VS_POL.

Test Plan:
1. Defaults, en=1 held -> hsync low for exactly 96 clocks starting 16 clocks after line_start. Line period 800 clocks; frame period 420000 clocks; vsync low for 2 lines starting at line 10.
2. Count pix_data_req per line and per frame -> 640 per active line, 0 on lines 0..44, 307200 per frame. address runs 0..307199 contiguous, then restarts at 0 on frame_start.
3. REQ_LEAD=3 with a 3-clock-delay memory model returning pix_data=address[15:0] -> at every rgb_valid clock, pix_data equals pix_y*640+pix_x (mod 2^16). Also pix_data=16'hF800 -> red=8'hFF, green=0, blue=0; pix_data=16'h07E0 -> red=0, green=8'hFF, blue=0.
4. Drop en at v=200 -> frame completes to v=524; then IDLE with hsync/vsync inactive and no frame_start. Re-raise en -> frame_start on the next clock.
5. HS_POL=1, VS_POL=1, 800x600 timing (40/128/88/800, 1/4/23/600) -> hsync high 128 clocks; line 1056 clocks; frame 628 lines; 480000 requests per frame.
6. Assert sys_rst_n=0 for one clock at h=700, v=300 -> next clock: outputs at reset values, address=0, state IDLE. Restart with en=1 -> first frame timing identical to scenario 1.
